uart_tx_frame: RTL and testbench

// Serialises bytes into UART frames on one line: start(0), 8 data bits LSB first, optional parity, stop(1).

---
 rtl/uart_tx_frame.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// A one-entry holding buffer lets the next byte start straight out of the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for the holding buffer to fill
// START  | start bit (0) for P cycles
// DATA   | data bits, shift[0] on the line, P cycles each
// PARITY | parity bit latched at frame start, P cycles
// STOP   | stop bit (1); last cycle pulses frame_done and may chain into START
module uart_tx_frame #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              par_enable,
  input  logic              par_type,
  input  logic [7:0]        prescale,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_next;
  logic              buf_full, buf_full_next;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] shift, shift_next;
  logic [7:0]        edge_cnt, edge_next;
  logic [7:0]        p_lat, p_next;
  logic [BW-1:0]     bit_cnt, bit_next;
  logic              par_en_lat, par_en_next;
  logic              par_bit, par_bit_next;
  logic              tx_next, last, load, accept;

  assign accept     = in_valid & in_ready;
  assign last       = (edge_cnt == p_lat - 8'd1);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && last;

  always_comb begin
    state_next    = state;
    edge_next     = edge_cnt;
    bit_next      = bit_cnt;
    shift_next    = shift;
    p_next        = p_lat;
    par_en_next   = par_en_lat;
    par_bit_next  = par_bit;
    load          = 1'b0;
    buf_full_next = buf_full;
    tx_next       = 1'b1;

    unique case (state)
      IDLE: begin
        edge_next = '0;
        bit_next  = '0;
        if (buf_full) begin
          state_next = START;
          load       = 1'b1;
        end
      end
      START: begin
        if (last) begin
          edge_next  = '0;
          state_next = DATA;
        end else begin
          edge_next = edge_cnt + 8'd1;
        end
      end
      DATA: begin
        if (last) begin
          edge_next  = '0;
          shift_next = shift >> 1;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_next   = '0;
            state_next = par_en_lat ? PARITY : STOP;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end else begin
          edge_next = edge_cnt + 8'd1;
        end
      end
      PARITY: begin
        if (last) begin
          edge_next  = '0;
          state_next = STOP;
        end else begin
          edge_next = edge_cnt + 8'd1;
        end
      end
      STOP: begin
        if (last) begin
          edge_next = '0;
          if (buf_full) begin
            state_next = START;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          edge_next = edge_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame settings are captured only here, so mid-frame input changes wait for the next frame.
    if (load) begin
      shift_next    = buf_data;
      p_next        = (prescale == 8'd0) ? 8'd1 : prescale;
      par_en_next   = par_enable;
      par_bit_next  = (^buf_data) ^ par_type;
      buf_full_next = 1'b0;
    end else if (accept) begin
      buf_full_next = 1'b1;
    end

    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      p_lat      <= 8'd1;
      par_en_lat <= 1'b0;
      par_bit    <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      in_ready   <= 1'b1;
      tx_out     <= 1'b1;
    end else begin
      state      <= state_next;
      edge_cnt   <= edge_next;
      bit_cnt    <= bit_next;
      shift      <= shift_next;
      p_lat      <= p_next;
      par_en_lat <= par_en_next;
      par_bit    <= par_bit_next;
      buf_full   <= buf_full_next;
      in_ready   <= ~buf_full_next;
      tx_out     <= tx_next;
      if (accept) buf_data <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: vector table, random frames against a line-level model,
// and hand-written back-to-back and mid-frame reset sequences.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       par_enable;
  logic       par_type;
  logic [7:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  uart_tx_frame #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .par_enable (par_enable),
    .par_type   (par_type),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] p;
    logic       pe;
    logic       pt;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected line level for bit slot k of a frame, from the frame format alone.
  function automatic logic model_bit(input logic [7:0] data, input logic pe, input logic pt, input int k);
    int nb;
    nb = 10 + int'(pe);
    if (k == 0) return 1'b0;
    if (k >= 1 && k <= 8) return data[k-1];
    if (pe && k == 9) return logic'(($countones(data) % 2 == 1) ^ pt);
    if (k == nb - 1) return 1'b1;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [7:0] data, input logic [7:0] p, input logic pe, input logic pt,
                           input int exp_len, input logic exp_par, input string tag);
    int peff, len, line_err, first_bad, fd_cnt, fd_at, busy_err, par_seen;
    peff      = (p == 8'd0) ? 1 : int'(p);
    len       = (10 + int'(pe)) * peff;
    line_err  = 0;
    first_bad = -1;
    fd_cnt    = 0;
    fd_at     = -1;
    busy_err  = 0;
    par_seen  = -1;
    @(negedge clk);
    check({tag, "_ready_idle"}, int'(in_ready), 1);
    in_data    = data;
    prescale   = p;
    par_enable = pe;
    par_type   = pt;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check({tag, "_ready_after_accept"}, int'(in_ready), 0);
    check({tag, "_line_before_start"}, int'(tx_out), 1);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (tx_out !== model_bit(data, pe, pt, c / peff)) begin
        line_err++;
        if (first_bad < 0) first_bad = c;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_at = c;
      end
      if (busy !== 1'b1) busy_err++;
      if (pe && c == 9 * peff) par_seen = int'(tx_out);
      if (c == 0) begin
        prescale   = 8'($urandom);
        par_enable = 1'($urandom);
        par_type   = 1'($urandom);
      end
    end
    check({tag, "_line_errors"}, line_err, 0);
    if (line_err != 0) $display("  %s first bad cycle %0d", tag, first_bad);
    check({tag, "_frame_done_count"}, fd_cnt, 1);
    check({tag, "_frame_len"}, fd_at + 1, exp_len);
    check({tag, "_busy_errors"}, busy_err, 0);
    if (pe) check({tag, "_parity_bit"}, par_seen, int'(exp_par));
    @(negedge clk);
    check({tag, "_idle_line"}, int'(tx_out), 1);
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'd8,  1'b0, 1'b0, 80,  1'b0};
    vecs[1] = '{8'h03, 8'd16, 1'b1, 1'b0, 176, 1'b0};
    vecs[2] = '{8'h03, 8'd16, 1'b1, 1'b1, 176, 1'b1};
    vecs[3] = '{8'hFF, 8'd3,  1'b1, 1'b0, 33,  1'b0};
    vecs[4] = '{8'h00, 8'd1,  1'b1, 1'b1, 11,  1'b1};
    vecs[5] = '{8'h80, 8'd0,  1'b0, 1'b0, 10,  1'b0};
    vecs[6] = '{8'h01, 8'd2,  1'b1, 1'b0, 22,  1'b1};

    // Reset held with a byte offered
    rst        = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'hFF;
    prescale   = 8'd4;
    par_enable = 1'b0;
    par_type   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", int'(tx_out), 1);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("post_rst_idle_errors", bad, 0);
    end

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].data, vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].exp_len, vecs[i].exp_par,
                $sformatf("vec%0d", i));

    // Back-to-back: 8'h55 then 8'hF0 offered during DATA, P=4, no parity
    begin
      int line_err, rdy_err, busy_err, fd_cnt, fd_bad;
      line_err = 0; rdy_err = 0; busy_err = 0; fd_cnt = 0; fd_bad = 0;
      @(negedge clk);
      prescale   = 8'd4;
      par_enable = 1'b0;
      par_type   = 1'b0;
      in_data    = 8'h55;
      in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
        logic exp_line;
        @(negedge clk);
        exp_line = (c < 40) ? model_bit(8'h55, 1'b0, 1'b0, c / 4) : model_bit(8'hF0, 1'b0, 1'b0, (c - 40) / 4);
        if (tx_out !== exp_line) line_err++;
        if (in_ready !== ((c >= 9 && c < 40) ? 1'b0 : 1'b1)) rdy_err++;
        if (busy !== 1'b1) busy_err++;
        if (frame_done) begin
          fd_cnt++;
          if (c != 39 && c != 79) fd_bad++;
        end
        if (c == 8) begin
          in_data  = 8'hF0;
          in_valid = 1'b1;
        end else if (c >= 9 && c < 20) begin
          in_data  = 8'h12;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      check("b2b_line_errors", line_err, 0);
      check("b2b_ready_errors", rdy_err, 0);
      check("b2b_busy_errors", busy_err, 0);
      check("b2b_frame_done_count", fd_cnt, 2);
      check("b2b_frame_done_misplaced", fd_bad, 0);
      @(negedge clk);
      check("b2b_idle_busy", int'(busy), 0);
    end

    // Random frames against the model
    for (int i = 0; i < 32; i++) begin
      logic [7:0] d, p;
      logic       pe, pt;
      int         peff;
      d    = 8'($urandom);
      p    = 8'($urandom_range(0, 6));
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      peff = (p == 8'd0) ? 1 : int'(p);
      run_frame(d, p, pe, pt, (10 + int'(pe)) * peff, logic'(($countones(d) % 2 == 1) ^ pt),
                $sformatf("rnd%0d", i));
    end

    // Reset in the middle of data bit 3, then a prescale=0 frame
    begin
      @(negedge clk);
      prescale   = 8'd4;
      par_enable = 1'b0;
      par_type   = 1'b0;
      in_data    = 8'h00;
      in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c <= 17; c++) @(negedge clk);
      check("midrst_bit3_line", int'(tx_out), 0);
      rst = 1'b0;
      #1;
      check("midrst_tx_out", int'(tx_out), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      run_frame(8'h81, 8'd0, 1'b0, 1'b0, 10, 1'b0, "p0");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
